cordic_ctrl: RTL and testbench
==============================

CORDIC_CTRL -- requirements
Module: cordic_ctrl

Interface
REQ-001 Parameter N_ITER, default 24: number of CORDIC micro-rotations per angle, legal range 2..32.
REQ-002 Parameter ADDR_W, default 5: width of iteration index; SHALL satisfy 2**ADDR_W >= N_ITER.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 start  input  1  request to process the angle currently on the z datapath input; sampled in IDLE only.
REQ-006 abort  input  1  cancel the current operation; no done pulse follows.
REQ-007 z_sign  input  1  sign bit (bit 31) of the current angle residue from the z datapath.
REQ-008 z_Sel  output  1  1 = z datapath takes the external angle; 0 = it takes its own feedback.
REQ-009 z_En  output  1  1 = z datapath commits the add/sub result; 0 = it holds the residue.
REQ-010 I_Sel  output  1  1 = arctan register loads the ROM value; 0 = it holds.
REQ-011 s  output  1  1 = add arctan to residue, 0 = subtract.
REQ-012 iter  output  ADDR_W  arctan ROM address and x/y shift amount for the current rotation.
REQ-013 busy  output  1  high from LOAD through the last UPDATE cycle.
REQ-014 done  output  1  one-cycle pulse; zo (residue) and x/y results are final.

Function
REQ-015 FSM states: IDLE, LOAD, FETCH, UPDATE, DONE.
REQ-016 IDLE: start=1 -> LOAD; otherwise stay; all control outputs 0.
REQ-017 LOAD (1 cycle): z_Sel=1, z_En=0, iter=0 -> FETCH.
REQ-018 FETCH (1 cycle): I_Sel=1, z_Sel=0, z_En=0 -> UPDATE.
REQ-019 UPDATE (1 cycle): z_En=1, z_Sel=0, I_Sel=0, s=z_sign sampled this cycle (negative residue adds, non-negative subtracts).
REQ-020 UPDATE transition: if iter==N_ITER-1 -> DONE; otherwise iter increments by 1 -> FETCH.
REQ-021 DONE (1 cycle): done=1, busy=0, iter holds N_ITER-1 -> IDLE.
REQ-022 s SHALL be 0 in every state other than UPDATE.
REQ-023 Latency: start accepted at edge T -> done=1 in cycle T+2+2*N_ITER (24 iterations: 50 cycles).
REQ-024 start while busy or in DONE is ignored; no queuing.
REQ-025 The earliest next accepted start is the cycle after DONE.
REQ-026 abort=1 in any state other than IDLE -> IDLE next edge; iter cleared; done not asserted.
REQ-027 abort takes priority over start and over the UPDATE->DONE transition in the same cycle.
REQ-028 iter never exceeds N_ITER-1 and never wraps.
REQ-029 At most one of z_Sel, I_Sel, z_En is high in any cycle.

Reset
REQ-030 While reset=0: state=IDLE, iter=0; z_Sel, z_En, I_Sel, s, busy and done all 0.
REQ-031 Reset asserted mid-operation aborts without a done pulse.
REQ-032 After reset deassertion, the first start SHALL be accepted at the first rising edge.

Structure
REQ-033 Shared package cordic_pkg SHALL hold the state enumeration, the N_ITER default and the ADDR_W default.
REQ-034 Single module with one natural sub-module, cordic_iter_cnt: clear, increment, terminal-count flag at N_ITER-1.
REQ-035 All outputs SHALL be registered or decoded from the state register and iter only; no combinational path from start to outputs.

Verification
REQ-036 Reset, then start pulse, z_sign held 0 -> exactly 24 UPDATE cycles, s=0 throughout, iter 0..23, done at cycle T+50, busy low thereafter.
REQ-037 z_sign toggling 1,0,1,... per UPDATE -> s matches the z_sign sampled in each UPDATE cycle.
REQ-038 start held high continuously -> operations back-to-back, one IDLE cycle between DONE and the next LOAD, done every 51 cycles.
REQ-039 abort in UPDATE with iter=10 -> IDLE next cycle, iter=0, no done; a later start runs a full 24-iteration pass.
REQ-040 reset=0 asserted asynchronously mid-FETCH -> all outputs 0 before the next clock edge; start after release accepted.
REQ-041 N_ITER=2 build -> done at T+6; ensure iter equals 0 then 1, with no overflow.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC rotation sequencer: state encoding and
// default build parameters.
package cordic_pkg;

    localparam int N_ITER_DEF = 24;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FETCH  = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    // Busy spans the angle load and every fetch/update pair, but not DONE.
    function automatic logic state_busy(input state_e st);
        return (st == S_LOAD) || (st == S_FETCH) || (st == S_UPDATE);
    endfunction

endpackage

// File: rtl/cordic_iter_cnt.sv
// Micro-rotation index counter: synchronous clear, saturating increment and a
// terminal-count flag on the last rotation.
module cordic_iter_cnt
    import cordic_pkg::*;
#(
    parameter int N_ITER = N_ITER_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] iter,
    output logic              tc
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_ITER - 1);

    logic [ADDR_W-1:0] iter_q;
    logic [ADDR_W-1:0] iter_d;

    assign tc = (iter_q == LAST);

    // Increment is blocked at terminal count so the index can never wrap.
    always_comb begin
        iter_d = iter_q;
        if (clr) begin
            iter_d = '0;
        end else if (inc && !tc) begin
            iter_d = iter_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iter_q <= '0;
        end else begin
            iter_q <= iter_d;
        end
    end

    assign iter = iter_q;

endmodule

// File: rtl/cordic_ctrl.sv
// CORDIC angle-mode sequencer: loads an angle, then runs N_ITER fetch/update
// pairs steering the z datapath, arctan register and rotation direction.
//
// state  | meaning
// IDLE   | waiting for start, all controls low
// LOAD   | z datapath takes the external angle
// FETCH  | arctan register loads ROM[iter]
// UPDATE | z datapath commits add/sub, direction from residue sign
// DONE   | one-cycle done pulse, results final
module cordic_ctrl
    import cordic_pkg::*;
#(
    parameter int N_ITER = N_ITER_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              z_sign,
    output logic              z_Sel,
    output logic              z_En,
    output logic              I_Sel,
    output logic              s,
    output logic [ADDR_W-1:0] iter,
    output logic              busy,
    output logic              done
);

    state_e state_q;
    state_e state_d;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   cnt_tc;

    cordic_iter_cnt #(
        .N_ITER (N_ITER),
        .ADDR_W (ADDR_W)
    ) u_iter_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .iter  (iter),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (cnt_tc) begin
                    state_d = S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                cnt_clr = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition, including the final UPDATE->DONE.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
            cnt_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode the state register only; the direction bit follows the
    // live residue sign during UPDATE.
    assign z_Sel = (state_q == S_LOAD);
    assign I_Sel = (state_q == S_FETCH);
    assign z_En  = (state_q == S_UPDATE);
    assign s     = (state_q == S_UPDATE) && z_sign;
    assign busy  = state_busy(state_q);
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_cordic_ctrl.sv
// Self-checking bench for cordic_ctrl: default build plus an N_ITER=2 build,
// checked cycle by cycle against a timeline model of the operation.
module tb_cordic_ctrl;

    localparam int NA = 24;
    localparam int NB = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       start_a = 1'b0, abort_a = 1'b0, z_sign_a = 1'b0;
    logic       z_sel_a, z_en_a, i_sel_a, s_a, busy_a, done_a;
    logic [4:0] iter_a;

    logic       start_b = 1'b0, abort_b = 1'b0, z_sign_b = 1'b0;
    logic       z_sel_b, z_en_b, i_sel_b, s_b, busy_b, done_b;
    logic [0:0] iter_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cordic_ctrl #(.N_ITER(NA), .ADDR_W(5)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .z_sign(z_sign_a),
        .z_Sel(z_sel_a), .z_En(z_en_a), .I_Sel(i_sel_a), .s(s_a),
        .iter(iter_a), .busy(busy_a), .done(done_a)
    );

    cordic_ctrl #(.N_ITER(NB), .ADDR_W(1)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .z_sign(z_sign_b),
        .z_Sel(z_sel_b), .z_En(z_en_b), .I_Sel(i_sel_b), .s(s_b),
        .iter(iter_b), .busy(busy_b), .done(done_b)
    );

    // Expected outputs j cycles after the accepting edge (j<0: idle).
    // Flags are {z_Sel, I_Sel, z_En, s, busy, done}.
    function automatic void model(input int j, input int n, input logic zs,
                                  output logic [5:0] f, output int it);
        if (j == 0) begin
            f = 6'b100010; it = 0;
        end else if (j >= 1 && j <= 2*n) begin
            it = (j - 1) / 2;
            if (j % 2 == 1) f = 6'b010010;
            else            f = {3'b001, zs, 2'b10};
        end else if (j == 2*n + 1) begin
            f = 6'b000001; it = n - 1;
        end else begin
            f = 6'b000000; it = 0;
        end
    endfunction

    task automatic check(input int which, input string tag, input logic [5:0] ef, input int ei);
        logic [5:0] of;
        int         oi;
        if (which == 0) begin
            of = {z_sel_a, i_sel_a, z_en_a, s_a, busy_a, done_a};
            oi = int'(iter_a);
        end else begin
            of = {z_sel_b, i_sel_b, z_en_b, s_b, busy_b, done_b};
            oi = int'(iter_b);
        end
        total++;
        assert ({of, oi} === {ef, ei}) else begin
            bad++;
            $error("FAIL %s: flags=%b iter=%0d, expected flags=%b iter=%0d", tag, of, oi, ef, ei);
        end
    endtask

    task automatic drive(input int which, input logic st, input logic ab, input logic zs);
        if (which == 0) begin
            start_a = st; abort_a = ab; z_sign_a = zs;
        end else begin
            start_b = st; abort_b = ab; z_sign_b = zs;
        end
    endtask

    // Called at posedge+1 with the DUT idle. Requests an operation and checks
    // ncyc cycles. hold keeps start high throughout (back-to-back); otherwise
    // start is randomly toggled only while the DUT must ignore it.
    task automatic run(input int which, input int ncyc, input bit hold,
                       input int abort_c, input string tag);
        int         n;
        int         j;
        bit         aborted;
        logic       zs;
        logic       st;
        logic [5:0] ef;
        int         ei;
        n = (which == 0) ? NA : NB;
        aborted = 1'b0;
        drive(which, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int c = 0; c < ncyc; c++) begin
            zs = 1'($urandom);
            if (hold) st = (c != ncyc - 1);
            else      st = (!aborted && c <= 2*n + 1) ? 1'($urandom) : 1'b0;
            drive(which, st, (c == abort_c), zs);
            #2;
            j = aborted ? -1 : (hold ? c % (2*n + 3) : c);
            model(j, n, zs, ef, ei);
            check(which, tag, ef, ei);
            if (c == abort_c) aborted = 1'b1;
            @(posedge clk); #1;
        end
        drive(which, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check(0, "reset_a", 6'b0, 0);
        check(1, "reset_b", 6'b0, 0);
        reset = 1'b1;

        run(0, 2*NA + 3, 1'b0, -1, "op_first");
        run(0, 2*NA + 3, 1'b0, -1, "op_second");
        run(0, 3*(2*NA + 3), 1'b1, -1, "back_to_back");
        run(0, 2*NA + 3, 1'b0, 22, "abort_iter10");
        run(0, 2*NA + 3, 1'b0, -1, "after_abort");

        // Leave DUT A mid-FETCH (iter 2), then reset between clock edges.
        run(0, 5, 1'b0, -1, "pre_reset");
        #1 reset = 1'b0;
        #1;
        check(0, "async_reset", 6'b0, 0);
        @(posedge clk); #1;
        check(0, "reset_held", 6'b0, 0);
        reset = 1'b1;
        run(0, 2*NA + 3, 1'b0, -1, "after_reset");

        run(1, 2*NB + 3, 1'b0, -1, "n2_op");
        run(1, 3*(2*NB + 3), 1'b1, -1, "n2_back_to_back");
        run(1, 2*NB + 3, 1'b0, 4, "n2_abort_last");
        run(1, 2*NB + 3, 1'b0, -1, "n2_after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
